// File: rtl/pixel_mixer_if.sv
// pixel_mixer_if: CPU palette bus for pixel_mixer.
// A strobe (WR or RD) is honoured on every clock edge where PAL_CS is also
// high; there is no back-pressure. Read data appears on DOUT one clock after
// the read strobe and holds until the next read.
interface pixel_mixer_if;
  logic [15:0] DIN;
  logic [15:0] DOUT;
  logic [19:0] A;
  logic [1:0]  BYTE_SEL;
  logic        PAL_CS;
  logic        RD;
  logic        WR;

  modport master (output DIN, A, BYTE_SEL, PAL_CS, RD, WR, input DOUT);
  modport slave  (input DIN, A, BYTE_SEL, PAL_CS, RD, WR, output DOUT);
endinterface

// File: rtl/pixel_mixer.sv
// pixel_mixer: per-pixel priority mixer for tile layers A/B and sprites,
// followed by a 512x16 CPU-writable palette and registered 5:5:5 output.
// Optional feature macro LAYER_MASK_EN adds DBG_MASK[2:0] (A, B, sprite)
// to force layers transparent before priority resolution.
// Pipeline: stage 1 (CE tick n) registers palette index + blanking, the
// video RAM port reads on the next clock, stage 2 (CE tick n+1) registers
// the colour. Requires CE_PIX at most every second clock.
module pixel_mixer #(
  parameter int PAL_AW = 9
) (
  input  logic         CLK_32M,
  input  logic         RESET_N,
  input  logic         CE_PIX,
  input  logic [3:0]   A_BIT,
  input  logic [3:0]   B_BIT,
  input  logic [3:0]   A_COL,
  input  logic [3:0]   B_COL,
  input  logic         A_CP15,
  input  logic         A_CP8,
  input  logic         B_CP15,
  input  logic         B_CP8,
  input  logic [3:0]   S_BIT,
  input  logic [3:0]   S_COL,
  input  logic         HBLANK,
  input  logic         VBLANK,
`ifdef LAYER_MASK_EN
  input  logic [2:0]   DBG_MASK,
`endif
  output logic [4:0]   R,
  output logic [4:0]   G,
  output logic [4:0]   B,
  output logic         HB_OUT,
  output logic         VB_OUT,
  pixel_mixer_if.slave bus
);

  logic [2:0]        layer_mask;
  logic              a_opaque, b_opaque, s_opaque;
  logic              a_high, b_high;
  logic [PAL_AW-1:0] pix_idx;
  logic [PAL_AW-1:0] idx_q;
  logic              hb_q, vb_q;
  logic [15:0]       ram_q;
  logic [15:0]       pal_mem [2**PAL_AW];
  logic [PAL_AW-1:0] cpu_addr;
  logic              unused_bits;

`ifdef LAYER_MASK_EN
  assign layer_mask = DBG_MASK;
`else
  assign layer_mask = 3'b000;
`endif

  assign cpu_addr = bus.A[PAL_AW:1];
  // Address bits outside the palette window and the spare colour bit.
  assign unused_bits = ^{bus.A[19:PAL_AW+1], bus.A[0], ram_q[15]};

  assign a_opaque = (A_BIT != 4'd0) && !layer_mask[0];
  assign b_opaque = (B_BIT != 4'd0) && !layer_mask[1];
  assign s_opaque = (S_BIT != 4'd0) && !layer_mask[2];
  assign a_high   = a_opaque && (A_CP15 || (A_CP8 && A_BIT[3]));
  assign b_high   = b_opaque && (B_CP15 || (B_CP8 && B_BIT[3]));

  // Priority resolution: first visible candidate in fixed order wins.
  always_comb begin
    pix_idx = '0;
    if (a_high)        pix_idx = {1'b0, A_COL, A_BIT};
    else if (b_high)   pix_idx = {1'b0, B_COL, B_BIT};
    else if (s_opaque) pix_idx = {1'b1, S_COL, S_BIT};
    else if (a_opaque) pix_idx = {1'b0, A_COL, A_BIT};
    else if (b_opaque) pix_idx = {1'b0, B_COL, B_BIT};
  end

  // Stage 1: register palette index and blanking on each pixel tick.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      idx_q <= '0;
      hb_q  <= 1'b1;
      vb_q  <= 1'b1;
    end else if (CE_PIX) begin
      idx_q <= pix_idx;
      hb_q  <= HBLANK;
      vb_q  <= VBLANK;
    end
  end

  // Palette storage: CPU byte-lane writes, ignored while in reset.
  always_ff @(posedge CLK_32M) begin
    if (RESET_N && bus.PAL_CS && bus.WR) begin
      if (bus.BYTE_SEL[0]) pal_mem[cpu_addr][7:0]  <= bus.DIN[7:0];
      if (bus.BYTE_SEL[1]) pal_mem[cpu_addr][15:8] <= bus.DIN[15:8];
    end
  end

  // Video read port: reads every clock, sees pre-write data on collision.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) ram_q <= '0;
    else          ram_q <= pal_mem[idx_q];
  end

  // CPU read port: one-clock latency, holds between reads.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N)                      bus.DOUT <= '0;
    else if (bus.PAL_CS && bus.RD)     bus.DOUT <= pal_mem[cpu_addr];
  end

  // Stage 2: register colour and blanking, black while blanked.
  always_ff @(posedge CLK_32M) begin
    if (!RESET_N) begin
      R      <= '0;
      G      <= '0;
      B      <= '0;
      HB_OUT <= 1'b1;
      VB_OUT <= 1'b1;
    end else if (CE_PIX) begin
      HB_OUT <= hb_q;
      VB_OUT <= vb_q;
      if (hb_q || vb_q) begin
        R <= '0;
        G <= '0;
        B <= '0;
      end else begin
        R <= ram_q[4:0];
        G <= ram_q[9:5];
        B <= ram_q[14:10];
      end
    end
  end

endmodule

// File: tb/tb_pixel_mixer.sv
// tb_pixel_mixer: directed and random checks of pixel_mixer against a
// palette/priority reference model. Define LAYER_MASK_EN to cover DBG_MASK.
module tb_pixel_mixer;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic [3:0] a_bit, b_bit, a_col, b_col, s_bit, s_col;
  logic       a_cp15, a_cp8, b_cp15, b_cp8;
  logic       hblank, vblank;
  logic [2:0] dbg_mask;
  logic [4:0] r, g, b;
  logic       hb_out, vb_out;

  pixel_mixer_if bus ();

  pixel_mixer #(.PAL_AW(9)) dut (
    .CLK_32M (clk),
    .RESET_N (rst_n),
    .CE_PIX  (ce),
    .A_BIT   (a_bit),
    .B_BIT   (b_bit),
    .A_COL   (a_col),
    .B_COL   (b_col),
    .A_CP15  (a_cp15),
    .A_CP8   (a_cp8),
    .B_CP15  (b_cp15),
    .B_CP8   (b_cp8),
    .S_BIT   (s_bit),
    .S_COL   (s_col),
    .HBLANK  (hblank),
    .VBLANK  (vblank),
`ifdef LAYER_MASK_EN
    .DBG_MASK(dbg_mask),
`endif
    .R       (r),
    .G       (g),
    .B       (b),
    .HB_OUT  (hb_out),
    .VB_OUT  (vb_out),
    .bus     (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state: output word is {hb, vb, B, G, R}
  localparam logic [16:0] RESET_OUT = {1'b1, 1'b1, 15'h0000};
  logic [16:0] exp_q[$];
  logic [15:0] pal_m [512];
  logic [16:0] last_out;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model: winner among the five candidates in priority order.
  function automatic logic [8:0] ref_index();
    logic       vis [5];
    logic [8:0] idx [5];
    logic a_vis, b_vis, s_vis;
    a_vis = (a_bit != 0) && !dbg_mask[0];
    b_vis = (b_bit != 0) && !dbg_mask[1];
    s_vis = (s_bit != 0) && !dbg_mask[2];
    vis[0] = a_vis && (a_cp15 || (a_cp8 && a_bit >= 8)); idx[0] = 9'(a_col * 16 + a_bit);
    vis[1] = b_vis && (b_cp15 || (b_cp8 && b_bit >= 8)); idx[1] = 9'(b_col * 16 + b_bit);
    vis[2] = s_vis;                                       idx[2] = 9'(256 + s_col * 16 + s_bit);
    vis[3] = a_vis;                                       idx[3] = idx[0];
    vis[4] = b_vis;                                       idx[4] = idx[1];
    for (int i = 0; i < 5; i++) if (vis[i]) return idx[i];
    return 9'h000;
  endfunction

  function automatic logic [16:0] ref_out();
    if (hblank || vblank) return {hblank, vblank, 15'h0000};
    return {2'b00, pal_m[ref_index()][14:0]};
  endfunction

  function automatic logic [16:0] dut_out();
    return {hb_out, vb_out, b, g, r};
  endfunction

  // Driver: one pixel tick (CE high for one clock, then three idle clocks).
  task automatic tick(input string tag);
    logic [16:0] e, want;
    e = ref_out();
    ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    if (rst_n) begin
      want = exp_q.pop_front();
      chk(tag, 32'(dut_out()), 32'(want));
      exp_q.push_back(e);
    end else begin
      chk({tag, "_rst_out"}, 32'(dut_out()), 32'(RESET_OUT));
      chk({tag, "_rst_dout"}, 32'(bus.DOUT), 32'h0);
      exp_q = {};
      exp_q.push_back(RESET_OUT);
    end
    last_out = dut_out();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input int addr, input logic [15:0] d, input logic [1:0] sel,
                           input bit upd);
    bus.A        = {10'($urandom), 9'(addr), 1'($urandom)};
    bus.DIN      = d;
    bus.BYTE_SEL = sel;
    bus.PAL_CS   = 1'b1;
    bus.WR       = 1'b1;
    @(posedge clk); #1;
    bus.PAL_CS = 1'b0;
    bus.WR     = 1'b0;
    if (upd) begin
      if (sel[0]) pal_m[addr][7:0]  = d[7:0];
      if (sel[1]) pal_m[addr][15:8] = d[15:8];
    end
  endtask

  task automatic cpu_read(input string tag, input int addr, input logic [15:0] expv);
    bus.A      = {10'($urandom), 9'(addr), 1'($urandom)};
    bus.PAL_CS = 1'b1;
    bus.RD     = 1'b1;
    @(posedge clk); #1;
    bus.PAL_CS = 1'b0;
    bus.RD     = 1'b0;
    chk(tag, 32'(bus.DOUT), 32'(expv));
  endtask

  task automatic set_pix(input logic [3:0] ab, ac, input logic a15, a8,
                         input logic [3:0] bb, bc, input logic b15, b8,
                         input logic [3:0] sb, sc);
    a_bit = ab; a_col = ac; a_cp15 = a15; a_cp8 = a8;
    b_bit = bb; b_col = bc; b_cp15 = b15; b_cp8 = b8;
    s_bit = sb; s_col = sc;
  endtask

  // Directed and random stimulus
  initial begin
    rst_n = 1'b0; ce = 1'b0;
    set_pix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hblank = 1'b0; vblank = 1'b0; dbg_mask = 3'b000;
    bus.DIN = '0; bus.A = '0; bus.BYTE_SEL = '0;
    bus.PAL_CS = 1'b0; bus.RD = 1'b0; bus.WR = 1'b0;
    exp_q.push_back(RESET_OUT);
    last_out = RESET_OUT;

    // Reset with CE toggling every 4 clocks
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) tick("reset_hold");
    rst_n = 1'b1;

    // Fill palette with random data, then fix a few directed entries
    for (int i = 0; i < 512; i++) cpu_write(i, 16'($urandom), 2'b11, 1'b1);
    cpu_write(9'h000, 16'h4444, 2'b11, 1'b1);
    cpu_write(9'h113, 16'h1111, 2'b11, 1'b1);
    cpu_write(9'h025, 16'h2222, 2'b11, 1'b1);
    cpu_write(9'h039, 16'h3333, 2'b11, 1'b1);

    // CPU readback and byte lanes
    cpu_write(9'h123, 16'h7FFF, 2'b11, 1'b1);
    cpu_read("rd_full", 9'h123, 16'h7FFF);
    cpu_write(9'h123, 16'h0000, 2'b01, 1'b1);
    cpu_read("rd_lane0", 9'h123, 16'h7F00);
    @(posedge clk); #1;
    chk("dout_hold", 32'(bus.DOUT), 32'h7F00);

    // First pixel after release: blank for one tick, then visible
    set_pix(5, 2, 1, 0, 0, 0, 0, 0, 3, 1);
    tick("first_a");
    chk("first_blanked", 32'(hb_out), 32'h1);
    set_pix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("first_b");
    chk("first_visible", 32'({b, g, r}), 32'(15'h2222 & 15'h7FFF));

    // Sprite beats low-priority A
    set_pix(5, 2, 0, 0, 0, 0, 0, 0, 3, 1);
    tick("spr_a"); tick("spr_b");
    chk("spr_wins", 32'({b, g, r}), 32'(15'h1111));
    // A with CP15 beats sprite
    set_pix(5, 2, 1, 0, 0, 0, 0, 0, 3, 1);
    tick("cp15_a"); tick("cp15_b");
    chk("cp15_wins", 32'({b, g, r}), 32'(15'h2222));
    // CP8 needs BIT[3]
    set_pix(4, 2, 0, 1, 0, 0, 0, 0, 3, 1);
    tick("cp8lo_a"); tick("cp8lo_b");
    chk("cp8_bit3_clear", 32'({b, g, r}), 32'(15'h1111));
    set_pix(9, 3, 0, 1, 0, 0, 0, 0, 3, 1);
    tick("cp8hi_a"); tick("cp8hi_b");
    chk("cp8_bit3_set", 32'({b, g, r}), 32'(15'h3333));
    // All transparent -> background entry 0
    set_pix(0, 2, 1, 1, 0, 4, 1, 1, 0, 1);
    tick("bg_a"); tick("bg_b");
    chk("background", 32'({b, g, r}), 32'(15'h4444));
    // Horizontal blank forces black two ticks later
    set_pix(5, 2, 1, 0, 0, 0, 0, 0, 3, 1);
    hblank = 1'b1;
    tick("hb_a");
    chk("hb_not_yet", 32'(hb_out), 32'h0);
    hblank = 1'b0;
    tick("hb_b");
    chk("hb_rgb", 32'({b, g, r}), 32'h0);
    chk("hb_flag", 32'(hb_out), 32'h1);

`ifdef LAYER_MASK_EN
    // Masked A-high pixel: sprite shows instead
    set_pix(5, 2, 1, 0, 0, 0, 0, 0, 3, 1);
    dbg_mask = 3'b001;
    tick("mask_a"); tick("mask_b");
    chk("mask_a_off", 32'({b, g, r}), 32'(15'h1111));
    dbg_mask = 3'b000;
`endif

    // Outputs hold while CE stays low
    set_pix(9, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    tick("hold_a");
    set_pix(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("hold_no_ce", 32'(dut_out()), 32'(last_out));

    // Palette write becomes visible to the next registered index
    cpu_write(9'h025, 16'h5A5A, 2'b11, 1'b1);
    set_pix(5, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tick("wr_vis_a"); tick("wr_vis_b");

    // Random pixels against the model
    for (int n = 0; n < 300; n++) begin
      set_pix(4'($urandom_range(0, 15)), 4'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom_range(0, 15)), 4'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom_range(0, 15)), 4'($urandom));
      hblank = ($urandom_range(0, 7) == 0);
      vblank = ($urandom_range(0, 15) == 0);
`ifdef LAYER_MASK_EN
      dbg_mask = 3'($urandom);
`endif
      tick("rand");
    end
    hblank = 1'b0; vblank = 1'b0; dbg_mask = 3'b000;

    // Mid-line reset: immediate effect, writes ignored, refill after release
    set_pix(5, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    tick("pre_rst_a"); tick("pre_rst_b");
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_immediate", 32'(dut_out()), 32'(RESET_OUT));
    cpu_write(9'h113, 16'hFFFF, 2'b11, 1'b0);
    tick("rst_mid");
    rst_n = 1'b1;
    set_pix(5, 2, 0, 0, 0, 0, 0, 0, 3, 1);
    tick("refill_a");
    tick("refill_b");
    chk("refill_sprite", 32'({b, g, r}), 32'(15'h1111));
    cpu_read("rst_write_ignored", 9'h113, 16'h1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
